bubble_sort_engine: RTL and testbench

//  Owns the N-entry array that the VGA bar renderer draws, and sorts it ascending
//  in place with bubble sort.
//  - Writer side of the display array: the renderer only reads it, through a

---
 rtl/bubble_sort_engine_pkg.sv | 25 ++
 rtl/bubble_sort_engine_if.sv | 36 +++
 rtl/bubble_sort_engine_regfile.sv | 55 +++++
 rtl/bubble_sort_engine.sv | 135 +++++++++++++
 tb/tb_bubble_sort_engine.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bubble_sort_engine_pkg.sv
// Shared definitions for the bubble sort engine.
//   - default geometry (entries, entry width, address width, counter width)
//   - the worst-case swap count N*(N-1)/2 for the default geometry
//   - sort state encoding
package sort_pkg;

  localparam int SORT_N     = 32;
  localparam int SORT_W     = 8;
  localparam int SORT_AW    = 5;
  localparam int SORT_CNT_W = 16;

  // A reversed array needs exactly this many swaps, one per compare.
  localparam int SORT_MAX_SWAPS = SORT_N * (SORT_N - 1) / 2;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_SORT = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_SORT = STATE_SORT,
    ST_DONE = STATE_DONE
  } sort_state_e;

endpackage

// File: rtl/bubble_sort_engine_if.sv
// Control, load, renderer-read and status bundle of the bubble sort engine.
//   master: the controller/renderer side (drives step_en, start, abort, load, rd_addr)
//   slave : the engine (drives rd_data, busy, done, cmp_idx, swap_count, pass_count)
interface bubble_sort_engine_if
  import sort_pkg::*;
#(
  parameter int W     = SORT_W,
  parameter int AW    = SORT_AW,
  parameter int CNT_W = SORT_CNT_W
) ();

  logic             step_en;
  logic             start;
  logic             abort;
  logic             ld_valid;
  logic [AW-1:0]    ld_addr;
  logic [W-1:0]     ld_data;
  logic [AW-1:0]    rd_addr;
  logic [W-1:0]     rd_data;
  logic             busy;
  logic             done;
  logic [AW-1:0]    cmp_idx;
  logic [CNT_W-1:0] swap_count;
  logic [CNT_W-1:0] pass_count;

  modport master (
    output step_en, start, abort, ld_valid, ld_addr, ld_data, rd_addr,
    input  rd_data, busy, done, cmp_idx, swap_count, pass_count
  );

  modport slave (
    input  step_en, start, abort, ld_valid, ld_addr, ld_data, rd_addr,
    output rd_data, busy, done, cmp_idx, swap_count, pass_count
  );

endinterface

// File: rtl/bubble_sort_engine_regfile.sv
// sort_regfile: N x W display array owned by the bubble sort engine.
//   clk, reset_n        : clock, async active-low reset (array resets to N-1-i)
//   ld_we/ld_addr/ld_data : single-entry load write port
//   sw_we               : exchange entries cmp_idx and cmp_idx+1
//   cmp_idx             : compare pair index; cmp_lo=a[cmp_idx], cmp_hi=a[cmp_idx+1]
//   rd_addr/rd_data     : combinational renderer read, 0 when rd_addr>=N
module sort_regfile
  import sort_pkg::*;
#(
  parameter int N  = SORT_N,
  parameter int W  = SORT_W,
  parameter int AW = SORT_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic          sw_we,
  input  logic [AW-1:0] cmp_idx,
  output logic [W-1:0]  cmp_lo,
  output logic [W-1:0]  cmp_hi,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0]  mem_r [N];
  logic [AW-1:0] cmp_nxt_s;
  logic          ld_in_range_s;
  logic          rd_in_range_s;

  // One extra zero bit keeps the range checks meaningful when N is a power of two.
  assign cmp_nxt_s     = cmp_idx + AW'(1);
  assign ld_in_range_s = ({1'b0, ld_addr} < (AW+1)'(N));
  assign rd_in_range_s = ({1'b0, rd_addr} < (AW+1)'(N));

  assign cmp_lo  = mem_r[cmp_idx];
  assign cmp_hi  = mem_r[cmp_nxt_s];
  assign rd_data = rd_in_range_s ? mem_r[rd_addr] : '0;

  // Array storage: reverse-order reset; swap and load are never requested together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= W'(N - 1 - i);
      end
    end else if (sw_we) begin
      mem_r[cmp_idx]   <= cmp_hi;
      mem_r[cmp_nxt_s] <= cmp_lo;
    end else if (ld_we && ld_in_range_s) begin
      mem_r[ld_addr] <= ld_data;
    end
  end

endmodule

// File: rtl/bubble_sort_engine.sv
// bubble_sort_engine: in-place ascending bubble sort of the display array,
// one compare per step_en tick.
//   clk     : system clock
//   reset_n : async active-low reset
//   bus     : slave side of bubble_sort_engine_if (step_en/start/abort, load port,
//             renderer read port, busy/done/cmp_idx/swap_count/pass_count)
module bubble_sort_engine
  import sort_pkg::*;
#(
  parameter int N     = SORT_N,
  parameter int W     = SORT_W,
  parameter int AW    = SORT_AW,
  parameter int CNT_W = SORT_CNT_W
) (
  input logic                 clk,
  input logic                 reset_n,
  bubble_sort_engine_if.slave bus
);

  sort_state_e      state_r;
  logic [AW-1:0]    j_r;
  logic [AW-1:0]    last_r;
  logic [CNT_W-1:0] swap_cnt_r;
  logic [CNT_W-1:0] pass_cnt_r;
  logic             swapped_r;
  logic             busy_r;
  logic             done_r;

  logic [W-1:0]     cmp_lo_s;
  logic [W-1:0]     cmp_hi_s;
  logic             step_s;
  logic             swap_s;
  logic             seen_swap_s;
  logic             ld_we_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Abort suppresses the compare so the array is left exactly as it was.
  assign step_s      = (state_r == ST_SORT) && bus.step_en && !bus.abort;
  // Strict greater-than: equal entries stay put, keeping the sort stable.
  assign swap_s      = step_s && (cmp_lo_s > cmp_hi_s);
  assign seen_swap_s = swapped_r || swap_s;
  assign ld_we_s     = bus.ld_valid && (state_r != ST_SORT);

  sort_regfile #(.N(N), .W(W), .AW(AW)) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .ld_we   (ld_we_s),
    .ld_addr (bus.ld_addr),
    .ld_data (bus.ld_data),
    .sw_we   (swap_s),
    .cmp_idx (j_r),
    .cmp_lo  (cmp_lo_s),
    .cmp_hi  (cmp_hi_s),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

  // Sort FSM with pass bookkeeping, statistics and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      j_r        <= '0;
      last_r     <= '0;
      swap_cnt_r <= '0;
      pass_cnt_r <= '0;
      swapped_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else if (bus.abort) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_r    <= ST_SORT;
            j_r        <= '0;
            last_r     <= AW'(N - 2);
            swap_cnt_r <= '0;
            pass_cnt_r <= '0;
            swapped_r  <= 1'b0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
          end else if (bus.ld_valid) begin
            // New data invalidates a finished result.
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_SORT: begin
          if (step_s) begin
            if (swap_s) begin
              swap_cnt_r <= sat_inc(swap_cnt_r);
            end
            if (j_r < last_r) begin
              j_r       <= j_r + AW'(1);
              swapped_r <= seen_swap_s;
            end else begin
              pass_cnt_r <= sat_inc(pass_cnt_r);
              // A clean pass proves the array sorted; last==0 means nothing left to order.
              if (!seen_swap_s || (last_r == '0)) begin
                state_r   <= ST_DONE;
                busy_r    <= 1'b0;
                done_r    <= 1'b1;
                swapped_r <= seen_swap_s;
              end else begin
                last_r    <= last_r - AW'(1);
                j_r       <= '0;
                swapped_r <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.cmp_idx    = j_r;
  assign bus.swap_count = swap_cnt_r;
  assign bus.pass_count = pass_cnt_r;

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Self-checking bench for bubble_sort_engine: directed and randomized arrays,
// checked against a plain array-based bubble sort reference.
module tb_bubble_sort_engine;
  import sort_pkg::*;

  localparam int N  = SORT_N;
  localparam int NC = SORT_MAX_SWAPS;   // most compares any run can take

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  bubble_sort_engine_if bus ();

  bubble_sort_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int stim     [N];
  int m_sorted [N];
  int tr_j    [NC];
  int tr_swc  [NC];
  int tr_pass [NC];
  int tr_lo   [NC];
  int tr_hi   [NC];
  int m_cmps, m_swaps, m_passes;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: textbook bubble sort with early exit, recording every compare.
  task automatic model_run();
    int a [N];
    bit sw;
    int t;
    for (int i = 0; i < N; i++) a[i] = stim[i];
    m_cmps = 0; m_swaps = 0; m_passes = 0;
    for (int last = N - 2; last >= 0; last--) begin
      sw = 0;
      for (int j = 0; j <= last; j++) begin
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
          m_swaps++;
          sw = 1;
        end
        if (j == last) m_passes++;
        tr_j[m_cmps]    = j;
        tr_lo[m_cmps]   = a[j];
        tr_hi[m_cmps]   = a[j+1];
        tr_swc[m_cmps]  = m_swaps;
        tr_pass[m_cmps] = m_passes;
        m_cmps++;
      end
      if (!sw) break;
    end
    for (int i = 0; i < N; i++) m_sorted[i] = a[i];
  endtask

  task automatic rd(input int addr, output int val);
    bus.rd_addr = 5'(addr);
    #1;
    val = int'(bus.rd_data);
  endtask

  task automatic check_array(input string tag, input bit reversed);
    int v;
    for (int i = 0; i < N; i++) begin
      rd(i, v);
      chk($sformatf("%s a[%0d]", tag, i), v, reversed ? (N - 1 - i) : m_sorted[i]);
    end
  endtask

  task automatic load_stim(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 5'(i);
      bus.ld_data  = 8'(stim[i]);
      @(posedge clk); #1;
    end
    bus.ld_valid = 1'b0;
  endtask

  // period>0: step every period-th cycle; period==0: random steps and random start noise.
  task automatic run_sort(input string tag, input int period, input bit ld_last);
    int  edges, ticks, v;
    bit  tick;
    model_run();
    if (ld_last) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 5'(N - 1);
      bus.ld_data  = 8'(stim[N-1]);
    end
    bus.start   = 1'b1;
    bus.step_en = 1'b0;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    bus.start    = 1'b0;
    edges = 1;
    ticks = 0;
    chk({tag, " busy"}, bus.busy, 1);
    while (!bus.done && edges < 20000) begin
      tick = (period > 0) ? ((edges % period) == 0) : ($urandom_range(0, 2) == 0);
      bus.step_en = tick;
      if (period == 0) bus.start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      bus.start = 1'b0;
      edges++;
      if (tick) ticks++;
      if (ticks > m_cmps) begin
        chk({tag, " overrun"}, ticks, m_cmps);
        break;
      end
      chk({tag, " swaps"},   bus.swap_count, (ticks == 0) ? 0 : tr_swc[ticks-1]);
      chk({tag, " passes"},  bus.pass_count, (ticks == 0) ? 0 : tr_pass[ticks-1]);
      chk({tag, " cmp_idx"}, bus.cmp_idx,    tr_j[(ticks < m_cmps) ? ticks : m_cmps - 1]);
      if (tick) begin
        rd(tr_j[ticks-1], v);
        chk({tag, " live_lo"}, v, tr_lo[ticks-1]);
        rd(tr_j[ticks-1] + 1, v);
        chk({tag, " live_hi"}, v, tr_hi[ticks-1]);
      end
    end
    bus.step_en = 1'b0;
    bus.start   = 1'b0;
    chk({tag, " in_time"},   edges < 20000, 1);
    chk({tag, " done"},      bus.done, 1);
    chk({tag, " busy_end"},  bus.busy, 0);
    chk({tag, " compares"},  ticks, m_cmps);
    chk({tag, " swaps_end"}, bus.swap_count, m_swaps);
    chk({tag, " pass_end"},  bus.pass_count, m_passes);
    if (period == 1) chk({tag, " done_edge"}, edges, m_cmps + 1);
    check_array(tag, 1'b0);
  endtask

  initial begin
    int v;
    bus.step_en = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.rd_addr = '0;
    reset_n = 1'b0;
    #23 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst cmp_idx", bus.cmp_idx, 0);
    chk("rst swaps", bus.swap_count, 0);
    chk("rst passes", bus.pass_count, 0);
    check_array("rst", 1'b1);

    // Abort after 100 compares of the reversed array; loads ignored while sorting
    for (int i = 0; i < N; i++) stim[i] = N - 1 - i;
    model_run();
    bus.start = 1'b1; bus.step_en = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (100) begin @(posedge clk); #1; end
    bus.step_en = 1'b0;
    chk("ab busy", bus.busy, 1);
    chk("ab swaps", bus.swap_count, tr_swc[99]);
    chk("ab passes", bus.pass_count, tr_pass[99]);
    chk("ab cmp_idx", bus.cmp_idx, tr_j[100]);
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd5; bus.ld_data = 8'hAB;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    rd(5, v);
    chk("ab ld_ignored", v == 32'hAB, 0);
    bus.abort = 1'b1; bus.start = 1'b1; bus.step_en = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.start = 1'b0; bus.step_en = 1'b0;
    chk("ab idle busy", bus.busy, 0);
    chk("ab idle done", bus.done, 0);
    chk("ab hold swaps", bus.swap_count, tr_swc[99]);
    chk("ab hold passes", bus.pass_count, tr_pass[99]);
    chk("ab hold cmp_idx", bus.cmp_idx, tr_j[100]);
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd5; bus.ld_data = 8'hAB;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    rd(5, v);
    chk("ab ld_applied", v, 32'hAB);
    for (int i = 0; i < N; i++) stim[i] = $urandom_range(0, 255);
    load_stim(N);
    run_sort("after_abort", 1, 1'b0);

    // Asynchronous reset mid-sort
    for (int i = 0; i < N; i++) stim[i] = $urandom_range(0, 255);
    load_stim(N);
    bus.start = 1'b1; bus.step_en = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (50) begin @(posedge clk); #1; end
    #3 reset_n = 1'b0;
    #1;
    chk("arst busy", bus.busy, 0);
    chk("arst done", bus.done, 0);
    chk("arst swaps", bus.swap_count, 0);
    chk("arst passes", bus.pass_count, 0);
    chk("arst cmp_idx", bus.cmp_idx, 0);
    bus.step_en = 1'b0;
    check_array("arst", 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reversed (reset contents): 496 compares/swaps, 31 passes, done at edge 497
    for (int i = 0; i < N; i++) stim[i] = N - 1 - i;
    run_sort("rev", 1, 1'b0);

    // Start held in DONE restarts; then abort back to idle
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("restart busy", bus.busy, 1);
    chk("restart swaps", bus.swap_count, 0);
    chk("restart passes", bus.pass_count, 0);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;

    // Already ascending
    for (int i = 0; i < N; i++) stim[i] = i;
    load_stim(N);
    run_sort("asc", 1, 1'b0);

    // All equal: no swaps, one pass
    for (int i = 0; i < N; i++) stim[i] = 8'h55;
    load_stim(N);
    run_sort("flat", 1, 1'b0);

    // Alternating 200/3, stepping every 4th cycle
    for (int i = 0; i < N; i++) stim[i] = (i % 2 == 0) ? 200 : 3;
    load_stim(N);
    run_sort("alt", 4, 1'b0);

    // Random arrays, random pacing, last entry loaded together with start
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) stim[i] = (r % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
      load_stim(N - 1);
      run_sort($sformatf("rnd%0d", r), 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
